// File: rtl/core2axi_pipe_if.sv
// AXI4 bus bundle used by the core2axi_pipe bridge; Master/Slave modports.
interface AXI_BUS #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_USER_WIDTH = 6
);
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_region;
  logic [3:0]                aw_qos;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_region;
  logic [3:0]                ar_qos;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_region, aw_qos, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_region, ar_qos, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_region, aw_qos, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_region, ar_qos, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/core2axi_pipe.sv
// Pipelined core LSU (req/gnt/rvalid) to AXI4 master bridge, up to MAX_OUTSTANDING beats in flight.
// Optional error reporting port data_err_o is enabled by defining CORE2AXI_PIPE_ERR_EN.
module core2axi_pipe #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_ID_WIDTH    = 6,
  parameter int AXI_USER_WIDTH  = 6,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      data_req_i,
  output logic                      data_gnt_o,
  output logic                      data_rvalid_o,
  input  logic [AXI_ADDR_WIDTH-1:0] data_addr_i,
  input  logic                      data_we_i,
  input  logic [3:0]                data_be_i,
  input  logic [31:0]               data_wdata_i,
  output logic [31:0]               data_rdata_o,
`ifdef CORE2AXI_PIPE_ERR_EN
  output logic                      data_err_o,
`endif
  AXI_BUS.Master                    master
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  function automatic logic [7:0] steer_strb64(input logic [3:0] be, input logic upper);
    return upper ? {be, 4'b0000} : {4'b0000, be};
  endfunction

  function automatic logic [31:0] pick_word64(input logic [63:0] d, input logic upper);
    return upper ? d[63:32] : d[31:0];
  endfunction

  logic                      ar_pend_p1, aw_pend_p1, w_pend_p1;
  logic                      out_we_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_p1;
  logic [31:0]               wdata_p1;
  logic [3:0]                be_p1;
  logic                      rvalid_p2;
  logic [31:0]               rdata_p2;
  logic [31:0]               rdata_sel;

  logic aw_hs, w_hs, ar_hs, r_hs, b_hs;
  logic slot_free, type_ok, room_ok, gnt, rsp_acc;

  assign aw_hs = aw_pend_p1 & master.aw_ready;
  assign w_hs  = w_pend_p1  & master.w_ready;
  assign ar_hs = ar_pend_p1 & master.ar_ready;
  assign r_hs  = master.r_valid;
  assign b_hs  = master.b_valid;

  // Slot counts as free when every still-pending channel of the issue register handshakes now.
  assign slot_free = (~aw_pend_p1 | aw_hs) & (~w_pend_p1 | w_hs) & (~ar_pend_p1 | ar_hs);
  assign type_ok   = (cnt_q == '0) | (data_we_i == out_we_q);
  assign room_ok   = cnt_q < CNT_W'(MAX_OUTSTANDING);
  assign gnt       = data_req_i & slot_free & room_ok & type_ok;
  assign rsp_acc   = (r_hs | b_hs) & (cnt_q != '0);

  assign data_gnt_o = gnt;

  // Issue stage (p1): one request held until its AXI address/data channels complete
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ar_pend_p1 <= 1'b0;
      aw_pend_p1 <= 1'b0;
      w_pend_p1  <= 1'b0;
      out_we_q   <= 1'b0;
    end else if (gnt) begin
      ar_pend_p1 <= ~data_we_i;
      aw_pend_p1 <= data_we_i;
      w_pend_p1  <= data_we_i;
      out_we_q   <= data_we_i;
    end else begin
      if (ar_hs) ar_pend_p1 <= 1'b0;
      if (aw_hs) aw_pend_p1 <= 1'b0;
      if (w_hs)  w_pend_p1  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (gnt) begin
      addr_p1  <= data_addr_i;
      wdata_p1 <= data_wdata_i;
      be_p1    <= data_be_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (gnt && !rsp_acc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (!gnt && rsp_acc) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  generate
    if (AXI_DATA_WIDTH == 64) begin : g_w64
      logic [MAX_OUTSTANDING-1:0] lane_mem;
      logic [PTR_W-1:0]           wr_ptr, rd_ptr;
      logic                       push, pop;

      assign push = gnt & ~data_we_i;
      assign pop  = r_hs & (cnt_q != '0);

      // Read lane FIFO: remembers addr[2] of each read so responses pick the right word.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end else begin
          if (push) wr_ptr <= (wr_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + PTR_W'(1);
          if (pop)  rd_ptr <= (rd_ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + PTR_W'(1);
        end
      end

      always_ff @(posedge clk_i) begin
        if (push) lane_mem[wr_ptr] <= data_addr_i[2];
      end

      assign master.w_data = {wdata_p1, wdata_p1};
      assign master.w_strb = steer_strb64(be_p1, addr_p1[2]);
      assign rdata_sel     = pick_word64(master.r_data, lane_mem[rd_ptr]);
    end else begin : g_w32
      assign master.w_data = wdata_p1;
      assign master.w_strb = be_p1;
      assign rdata_sel     = master.r_data;
    end
  endgenerate

  assign master.aw_id     = {AXI_ID_WIDTH{1'b0}};
  assign master.aw_addr   = addr_p1;
  assign master.aw_len    = 8'd0;
  assign master.aw_size   = 3'b010;
  assign master.aw_burst  = 2'b01;
  assign master.aw_lock   = 1'b0;
  assign master.aw_cache  = 4'd0;
  assign master.aw_prot   = 3'd0;
  assign master.aw_region = 4'd0;
  assign master.aw_qos    = 4'd0;
  assign master.aw_user   = {AXI_USER_WIDTH{1'b0}};
  assign master.aw_valid  = aw_pend_p1;

  assign master.w_last    = 1'b1;
  assign master.w_user    = {AXI_USER_WIDTH{1'b0}};
  assign master.w_valid   = w_pend_p1;

  assign master.b_ready   = 1'b1;

  assign master.ar_id     = {AXI_ID_WIDTH{1'b0}};
  assign master.ar_addr   = addr_p1;
  assign master.ar_len    = 8'd0;
  assign master.ar_size   = 3'b010;
  assign master.ar_burst  = 2'b01;
  assign master.ar_lock   = 1'b0;
  assign master.ar_cache  = 4'd0;
  assign master.ar_prot   = 3'd0;
  assign master.ar_region = 4'd0;
  assign master.ar_qos    = 4'd0;
  assign master.ar_user   = {AXI_USER_WIDTH{1'b0}};
  assign master.ar_valid  = ar_pend_p1;

  assign master.r_ready   = 1'b1;

  // Response stage (p2): registered pulse back to the core
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_p2 <= 1'b0;
      rdata_p2  <= '0;
    end else begin
      rvalid_p2 <= rsp_acc;
      if (rsp_acc && r_hs) rdata_p2 <= rdata_sel;
    end
  end

  assign data_rvalid_o = rvalid_p2;
  assign data_rdata_o  = rdata_p2;

`ifdef CORE2AXI_PIPE_ERR_EN
  logic err_p2;

  // resp[1] set means SLVERR or DECERR; a response with nothing outstanding is also an error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_p2 <= 1'b0;
    end else begin
      err_p2 <= (r_hs & (master.r_resp[1] | (cnt_q == '0))) |
                (b_hs & (master.b_resp[1] | (cnt_q == '0)));
    end
  end

  assign data_err_o = err_p2;
`endif

endmodule

// File: tb/tb_core2axi_pipe.sv
// Directed self-checking bench for core2axi_pipe: one 32-bit and one 64-bit instance.
`timescale 1ns/1ps
module tb_core2axi_pipe;

  int checks = 0;
  int errors = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req32 = 1'b0, req64 = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        gnt32, gnt64, rv32, rv64;
  logic [31:0] rd32, rd64;
`ifdef CORE2AXI_PIPE_ERR_EN
  logic        err32, err64;
`endif
  logic [31:0] exp_rd [4];

  always #5 clk = ~clk;

  AXI_BUS #(.AXI_DATA_WIDTH(32)) bus32 ();
  AXI_BUS #(.AXI_DATA_WIDTH(64)) bus64 ();

  core2axi_pipe #(.AXI_DATA_WIDTH(32), .MAX_OUTSTANDING(4)) dut32 (
    .clk_i(clk), .rst_ni(rst_n),
    .data_req_i(req32), .data_gnt_o(gnt32), .data_rvalid_o(rv32),
    .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rdata_o(rd32),
`ifdef CORE2AXI_PIPE_ERR_EN
    .data_err_o(err32),
`endif
    .master(bus32)
  );

  core2axi_pipe #(.AXI_DATA_WIDTH(64), .MAX_OUTSTANDING(4)) dut64 (
    .clk_i(clk), .rst_ni(rst_n),
    .data_req_i(req64), .data_gnt_o(gnt64), .data_rvalid_o(rv64),
    .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rdata_o(rd64),
`ifdef CORE2AXI_PIPE_ERR_EN
    .data_err_o(err64),
`endif
    .master(bus64)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_slaves();
    bus32.aw_ready = 0; bus32.w_ready = 0; bus32.ar_ready = 0;
    bus32.b_valid = 0; bus32.b_resp = 0; bus32.b_id = 0; bus32.b_user = 0;
    bus32.r_valid = 0; bus32.r_data = 0; bus32.r_resp = 0; bus32.r_id = 0;
    bus32.r_last = 1; bus32.r_user = 0;
    bus64.aw_ready = 0; bus64.w_ready = 0; bus64.ar_ready = 0;
    bus64.b_valid = 0; bus64.b_resp = 0; bus64.b_id = 0; bus64.b_user = 0;
    bus64.r_valid = 0; bus64.r_data = 0; bus64.r_resp = 0; bus64.r_id = 0;
    bus64.r_last = 1; bus64.r_user = 0;
  endtask

  initial begin
    exp_rd[0] = 32'h0000_0F00;
    exp_rd[1] = 32'hF000_0001;
    exp_rd[2] = 32'h0000_0F02;
    exp_rd[3] = 32'hF000_0003;
    idle_slaves();
    #2;
    checks++; if (rv32 !== 1'b0) begin errors++; $error("FAIL rst_rvalid32 observed=%0h expected=0", rv32); end
    checks++; if (rd32 !== 32'h0) begin errors++; $error("FAIL rst_rdata32 observed=%0h expected=0", rd32); end
    checks++; if (bus64.ar_valid !== 1'b0) begin errors++; $error("FAIL rst_arvalid64 observed=%0h expected=0", bus64.ar_valid); end
    checks++; if (bus64.aw_valid !== 1'b0) begin errors++; $error("FAIL rst_awvalid64 observed=%0h expected=0", bus64.aw_valid); end
    checks++; if (bus64.w_valid !== 1'b0) begin errors++; $error("FAIL rst_wvalid64 observed=%0h expected=0", bus64.w_valid); end
    checks++; if (gnt64 !== 1'b0) begin errors++; $error("FAIL rst_gnt64 observed=%0h expected=0", gnt64); end
    step(); step();
    rst_n = 1'b1;
    step();

    // Single 32-bit read
    req32 = 1; we = 0; addr = 32'h1000; #1;
    checks++; if (gnt32 !== 1'b1) begin errors++; $error("FAIL rd32_gnt observed=%0h expected=1", gnt32); end
    step();
    req32 = 0; #1;
    checks++; if (bus32.ar_valid !== 1'b1) begin errors++; $error("FAIL rd32_arvalid observed=%0h expected=1", bus32.ar_valid); end
    checks++; if (bus32.ar_addr !== 32'h1000) begin errors++; $error("FAIL rd32_araddr observed=%0h expected=1000", bus32.ar_addr); end
    checks++; if (bus32.ar_size !== 3'b010) begin errors++; $error("FAIL rd32_arsize observed=%0h expected=2", bus32.ar_size); end
    bus32.ar_ready = 1;
    step();
    bus32.ar_ready = 0; bus32.r_valid = 1; bus32.r_data = 32'hDEAD_BEEF; #1;
    checks++; if (bus32.ar_valid !== 1'b0) begin errors++; $error("FAIL rd32_arvalid_drop observed=%0h expected=0", bus32.ar_valid); end
    checks++; if (rv32 !== 1'b0) begin errors++; $error("FAIL rd32_rvalid_early observed=%0h expected=0", rv32); end
    step();
    bus32.r_valid = 0; #1;
    checks++; if (rv32 !== 1'b1) begin errors++; $error("FAIL rd32_rvalid observed=%0h expected=1", rv32); end
    checks++; if (rd32 !== 32'hDEAD_BEEF) begin errors++; $error("FAIL rd32_rdata observed=%0h expected=deadbeef", rd32); end
    step();
    checks++; if (rv32 !== 1'b0) begin errors++; $error("FAIL rd32_rvalid_pulse observed=%0h expected=0", rv32); end

    // Unexpected response with nothing outstanding is dropped
    bus32.b_valid = 1; bus32.b_resp = 2'b00;
    step();
    bus32.b_valid = 0; #1;
    checks++; if (rv32 !== 1'b0) begin errors++; $error("FAIL drop_no_pulse observed=%0h expected=0", rv32); end
`ifdef CORE2AXI_PIPE_ERR_EN
    checks++; if (err32 !== 1'b1) begin errors++; $error("FAIL drop_err observed=%0h expected=1", err32); end
`endif
    step();

    // 64-bit write with upper-lane steering
    req64 = 1; we = 1; addr = 32'h2004; be = 4'b0011; wdata = 32'h1234_5678; #1;
    checks++; if (gnt64 !== 1'b1) begin errors++; $error("FAIL wr64_gnt observed=%0h expected=1", gnt64); end
    step();
    req64 = 0; #1;
    checks++; if (bus64.aw_valid !== 1'b1) begin errors++; $error("FAIL wr64_awvalid observed=%0h expected=1", bus64.aw_valid); end
    checks++; if (bus64.w_valid !== 1'b1) begin errors++; $error("FAIL wr64_wvalid observed=%0h expected=1", bus64.w_valid); end
    checks++; if (bus64.aw_addr !== 32'h2004) begin errors++; $error("FAIL wr64_awaddr observed=%0h expected=2004", bus64.aw_addr); end
    checks++; if (bus64.w_strb !== 8'h30) begin errors++; $error("FAIL wr64_wstrb observed=%0h expected=30", bus64.w_strb); end
    checks++; if (bus64.w_data !== 64'h1234_5678_1234_5678) begin errors++; $error("FAIL wr64_wdata observed=%0h expected=1234567812345678", bus64.w_data); end
    checks++; if (bus64.w_last !== 1'b1) begin errors++; $error("FAIL wr64_wlast observed=%0h expected=1", bus64.w_last); end
    bus64.aw_ready = 1; bus64.w_ready = 1;
    step();
    bus64.aw_ready = 0; bus64.w_ready = 0; bus64.b_valid = 1; bus64.b_resp = 2'b10; #1;
    checks++; if (bus64.aw_valid !== 1'b0) begin errors++; $error("FAIL wr64_awvalid_drop observed=%0h expected=0", bus64.aw_valid); end
    checks++; if (bus64.w_valid !== 1'b0) begin errors++; $error("FAIL wr64_wvalid_drop observed=%0h expected=0", bus64.w_valid); end
    checks++; if (rv64 !== 1'b0) begin errors++; $error("FAIL wr64_no_early_rvalid observed=%0h expected=0", rv64); end
    step();
    bus64.b_valid = 0; bus64.b_resp = 2'b00; #1;
    checks++; if (rv64 !== 1'b1) begin errors++; $error("FAIL wr64_rvalid observed=%0h expected=1", rv64); end
`ifdef CORE2AXI_PIPE_ERR_EN
    checks++; if (err64 !== 1'b1) begin errors++; $error("FAIL wr64_err observed=%0h expected=1", err64); end
`endif
    step();
    checks++; if (rv64 !== 1'b0) begin errors++; $error("FAIL wr64_rvalid_pulse observed=%0h expected=0", rv64); end

    // AW accepted three cycles before W
    req64 = 1; we = 1; addr = 32'h3000; be = 4'hF; wdata = 32'hCAFE_F00D; #1;
    checks++; if (gnt64 !== 1'b1) begin errors++; $error("FAIL awfirst_gnt observed=%0h expected=1", gnt64); end
    step();
    addr = 32'h3008; be = 4'h1; wdata = 32'h0BAD_C0DE; bus64.aw_ready = 1; #1;
    checks++; if (gnt64 !== 1'b0) begin errors++; $error("FAIL awfirst_gnt_blocked0 observed=%0h expected=0", gnt64); end
    step();
    bus64.aw_ready = 0; #1;
    checks++; if (bus64.aw_valid !== 1'b0) begin errors++; $error("FAIL awfirst_aw_drop observed=%0h expected=0", bus64.aw_valid); end
    checks++; if (bus64.w_valid !== 1'b1) begin errors++; $error("FAIL awfirst_w_hold observed=%0h expected=1", bus64.w_valid); end
    checks++; if (gnt64 !== 1'b0) begin errors++; $error("FAIL awfirst_gnt_blocked1 observed=%0h expected=0", gnt64); end
    step();
    checks++; if (bus64.w_data !== 64'hCAFE_F00D_CAFE_F00D) begin errors++; $error("FAIL awfirst_wdata_stable observed=%0h expected=cafef00dcafef00d", bus64.w_data); end
    checks++; if (gnt64 !== 1'b0) begin errors++; $error("FAIL awfirst_gnt_blocked2 observed=%0h expected=0", gnt64); end
    step();
    bus64.w_ready = 1; #1;
    checks++; if (gnt64 !== 1'b1) begin errors++; $error("FAIL awfirst_gnt_on_w observed=%0h expected=1", gnt64); end
    step();
    req64 = 0; bus64.aw_ready = 1; #1;
    checks++; if (bus64.aw_valid !== 1'b1) begin errors++; $error("FAIL second_awvalid observed=%0h expected=1", bus64.aw_valid); end
    checks++; if (bus64.w_valid !== 1'b1) begin errors++; $error("FAIL second_wvalid observed=%0h expected=1", bus64.w_valid); end
    checks++; if (bus64.w_strb !== 8'h01) begin errors++; $error("FAIL second_wstrb observed=%0h expected=01", bus64.w_strb); end
    checks++; if (bus64.w_data !== 64'h0BAD_C0DE_0BAD_C0DE) begin errors++; $error("FAIL second_wdata observed=%0h expected=0badc0de0badc0de", bus64.w_data); end
    step();
    bus64.aw_ready = 0; bus64.w_ready = 0; bus64.b_valid = 1; #1;
    checks++; if ({bus64.aw_valid, bus64.w_valid} !== 2'b00) begin errors++; $error("FAIL second_valids_drop observed=%0h expected=0", {bus64.aw_valid, bus64.w_valid}); end
    step();
    #1;
    checks++; if (rv64 !== 1'b1) begin errors++; $error("FAIL b1_rvalid observed=%0h expected=1", rv64); end
    step();
    bus64.b_valid = 0; #1;
    checks++; if (rv64 !== 1'b1) begin errors++; $error("FAIL b2_rvalid observed=%0h expected=1", rv64); end
    step();
    checks++; if (rv64 !== 1'b0) begin errors++; $error("FAIL b_drained observed=%0h expected=0", rv64); end

    // Read followed by write: write waits for the read to drain
    req64 = 1; we = 0; addr = 32'h0000_0010; #1;
    checks++; if (gnt64 !== 1'b1) begin errors++; $error("FAIL rw_rd_gnt observed=%0h expected=1", gnt64); end
    step();
    we = 1; addr = 32'h0000_0020; be = 4'hF; wdata = 32'h5555_AAAA; bus64.ar_ready = 1; #1;
    checks++; if (gnt64 !== 1'b0) begin errors++; $error("FAIL rw_wr_blocked0 observed=%0h expected=0", gnt64); end
    step();
    bus64.ar_ready = 0; #1;
    checks++; if (gnt64 !== 1'b0) begin errors++; $error("FAIL rw_wr_blocked1 observed=%0h expected=0", gnt64); end
    bus64.r_valid = 1; bus64.r_data = 64'hAAAA_BBBB_CCCC_DDDD; #1;
    checks++; if (gnt64 !== 1'b0) begin errors++; $error("FAIL rw_wr_blocked2 observed=%0h expected=0", gnt64); end
    step();
    bus64.r_valid = 0; #1;
    checks++; if (gnt64 !== 1'b1) begin errors++; $error("FAIL rw_wr_gnt observed=%0h expected=1", gnt64); end
    checks++; if (rv64 !== 1'b1) begin errors++; $error("FAIL rw_rd_rvalid observed=%0h expected=1", rv64); end
    checks++; if (rd64 !== 32'hCCCC_DDDD) begin errors++; $error("FAIL rw_rd_lower observed=%0h expected=ccccdddd", rd64); end
    step();
    req64 = 0; bus64.aw_ready = 1; bus64.w_ready = 1; #1;
    checks++; if ({bus64.aw_valid, bus64.w_valid} !== 2'b11) begin errors++; $error("FAIL rw_wr_issued observed=%0h expected=3", {bus64.aw_valid, bus64.w_valid}); end
    step();
    bus64.aw_ready = 0; bus64.w_ready = 0; bus64.b_valid = 1;
    step();
    bus64.b_valid = 0; #1;
    checks++; if (rv64 !== 1'b1) begin errors++; $error("FAIL rw_wr_rvalid observed=%0h expected=1", rv64); end
    step();

    // Four back-to-back reads fill the outstanding window
    bus64.ar_ready = 1; we = 0;
    for (int k = 0; k < 4; k++) begin
      req64 = 1; addr = 32'(k * 4); #1;
      checks++; if (gnt64 !== 1'b1) begin errors++; $error("FAIL b2b_gnt observed=%0h expected=1", gnt64); end
      step();
    end
    addr = 32'h10; #1;
    checks++; if (gnt64 !== 1'b0) begin errors++; $error("FAIL b2b_fifth_blocked observed=%0h expected=0", gnt64); end
    repeat (10) step();
    checks++; if (gnt64 !== 1'b0) begin errors++; $error("FAIL b2b_fifth_still_blocked observed=%0h expected=0", gnt64); end
    req64 = 0;
    for (int k = 0; k < 4; k++) begin
      bus64.r_valid = 1;
      bus64.r_data = {32'hF000_0000 + 32'(k), 32'h0000_0F00 + 32'(k)};
      #1;
      if (k > 0) begin
        checks++; if (rv64 !== 1'b1) begin errors++; $error("FAIL b2b_rvalid observed=%0h expected=1", rv64); end
        checks++; if (rd64 !== exp_rd[k-1]) begin errors++; $error("FAIL b2b_rdata observed=%0h expected=%0h", rd64, exp_rd[k-1]); end
      end
      step();
    end
    bus64.r_valid = 0; #1;
    checks++; if (rv64 !== 1'b1) begin errors++; $error("FAIL b2b_rvalid_last observed=%0h expected=1", rv64); end
    checks++; if (rd64 !== exp_rd[3]) begin errors++; $error("FAIL b2b_rdata_last observed=%0h expected=%0h", rd64, exp_rd[3]); end
    step();
    checks++; if (rv64 !== 1'b0) begin errors++; $error("FAIL b2b_drained observed=%0h expected=0", rv64); end

    // Reset with two reads outstanding
    we = 0; req64 = 1; addr = 32'h40; #1;
    checks++; if (gnt64 !== 1'b1) begin errors++; $error("FAIL rst_rd0_gnt observed=%0h expected=1", gnt64); end
    step();
    addr = 32'h44; #1;
    checks++; if (gnt64 !== 1'b1) begin errors++; $error("FAIL rst_rd1_gnt observed=%0h expected=1", gnt64); end
    step();
    req64 = 0; bus64.ar_ready = 0; #1;
    checks++; if (bus64.ar_valid !== 1'b1) begin errors++; $error("FAIL rst_arvalid_pending observed=%0h expected=1", bus64.ar_valid); end
    #2;
    rst_n = 1'b0; #1;
    checks++; if (bus64.ar_valid !== 1'b0) begin errors++; $error("FAIL rst_mid_arvalid observed=%0h expected=0", bus64.ar_valid); end
    checks++; if (bus64.aw_valid !== 1'b0) begin errors++; $error("FAIL rst_mid_awvalid observed=%0h expected=0", bus64.aw_valid); end
    checks++; if (bus64.w_valid !== 1'b0) begin errors++; $error("FAIL rst_mid_wvalid observed=%0h expected=0", bus64.w_valid); end
    checks++; if (rv64 !== 1'b0) begin errors++; $error("FAIL rst_mid_rvalid observed=%0h expected=0", rv64); end
    checks++; if (rd64 !== 32'h0) begin errors++; $error("FAIL rst_mid_rdata observed=%0h expected=0", rd64); end
    step();
    rst_n = 1'b1;
    step();
    req64 = 1; we = 1; addr = 32'h80; #1;
    checks++; if (gnt64 !== 1'b1) begin errors++; $error("FAIL rst_cnt_cleared_gnt observed=%0h expected=1", gnt64); end
    req64 = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/core2axi_pipe.md
# core2axi_pipe

Pipelined core-data-port to AXI4 master bridge: the next generation of the single-transaction core-to-AXI adapter. It accepts the core LSU's req/gnt/rvalid protocol and keeps up to MAX_OUTSTANDING single-beat transactions in flight. It also supports 32- or 64-bit AXI data with byte-lane steering. It sits between the core data port and the AXI interconnect, driving one AXI_BUS.Master interface.

## Interface
- AXI_ADDR_WIDTH, 32: AXI and core address width.
- AXI_DATA_WIDTH, 32: AXI data width; legal values 32 or 64.
- AXI_ID_WIDTH, 6: AXI ID width; all IDs driven 0.
- AXI_USER_WIDTH, 6: AXI user width; all user fields driven 0.
- MAX_OUTSTANDING, 4: in-flight transaction limit; power of two, 1..16.
- clk_i  in  1  clock, all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- data_req_i  in  1  core request.
- data_gnt_o  out  1  request accepted this cycle.
- data_rvalid_o  out  1  one-cycle response pulse, read or write.
- data_addr_i  in  AXI_ADDR_WIDTH  byte address; bits [1:0] ignored.
- data_we_i  in  1  1 = write.
- data_be_i  in  4  byte enables.
- data_wdata_i  in  32  write data.
- data_rdata_o  out  32  read data, valid with data_rvalid_o.
- data_err_o  out  1  present only with CORE2AXI_PIPE_ERR_EN; see Configuration.
- master  AXI_BUS.Master  full AXI4 master port.

## Operation
- Constant AXI fields: len 0, size 3'b010, burst 2'b01, lock/cache/prot/region/qos 0, id 0, user 0, w_last 1.
- data_gnt_o = data_req_i & slot_free & (cnt < MAX_OUTSTANDING) & type_ok. The grant is combinational.
  - slot_free: the issue register is empty, or it is being fully accepted this cycle.
  - type_ok: cnt == 0, or data_we_i equals the type of the transactions currently outstanding.
- Mixed read/write traffic therefore drains before the type switches. This keeps responses in order.
- On grant, the request loads the issue register. A read drives ar_valid. A write drives aw_valid and w_valid.
- AW and W complete independently. Each valid drops after its own handshake. The slot frees when both have completed.
- cnt (width $clog2(MAX_OUTSTANDING)+1):
  - +1 on grant.
  - −1 on an R handshake or a B handshake.
  - Unchanged when both occur in the same cycle.
- 64-bit mode:
  - Write: w_data = {wdata, wdata}; w_strb = addr[2] ? {be, 4'b0} : {4'b0, be}.
  - Read: addr[2] is pushed into a MAX_OUTSTANDING-deep lane FIFO at grant and popped at the R handshake. data_rdata_o takes the upper word if the popped bit is 1, otherwise the lower word.
- r_ready and b_ready are held at 1. The core accepts every response.
- A response arriving with cnt == 0 is dropped and produces no pulse.

## Timing
- Reset values: data_gnt_o 0 (combinational, but cnt 0 and slot empty), data_rvalid_o 0, data_rdata_o 0, all AXI valids 0, cnt 0, FIFO empty, data_err_o 0.
- Cycle N: grant. Cycle N+1: ar_valid, or aw_valid with w_valid, is asserted from registers.
- data_rvalid_o is registered and pulses the cycle after the R or B handshake.
- Minimum read latency: gnt at N, ar_valid at N+1, r_valid at N+2, data_rvalid_o at N+3.
- Back-to-back throughput: one grant per cycle while the slave holds ready high and cnt < MAX_OUTSTANDING.
- AXI valid stability: once a valid is asserted, it and its payload stay stable until the handshake.
- Reset mid-operation clears all state immediately. In-flight AXI transactions are abandoned; the interconnect is reset by the same rst_ni.

## Configuration
- CORE2AXI_PIPE_ERR_EN defined:
  - The data_err_o port exists. It is registered and aligned with data_rvalid_o.
  - It is 1 when r_resp or b_resp is SLVERR or DECERR, or when a response is dropped (unexpected).
- CORE2AXI_PIPE_ERR_EN undefined:
  - No data_err_o port and no error logic.
  - resp fields are ignored.

## Test plan
- Single read, AXI_DATA_WIDTH=32, addr 0x1000, slave returns 0xDEADBEEF with 1-cycle ready -> ar_addr 0x1000 at N+1; data_rvalid_o at N+3 with 0xDEADBEEF.
- 64-bit write, addr 0x2004, be 4'b0011, wdata 0x12345678 -> w_strb 8'h30; w_data 0x12345678_12345678; AW and W complete; one data_rvalid_o after b_valid.
- Four back-to-back 64-bit reads at addr 0x0, 0x4, 0x8, 0xC, MAX_OUTSTANDING=4, r_valid delayed 10 cycles -> four grants in consecutive cycles; fifth request not granted; rdata selects lower, upper, lower, upper words in order.
- Read followed immediately by write -> write gnt held low until the read's R handshake makes cnt 0, then granted.
- AW ready 3 cycles before W ready -> aw_valid drops after its handshake; w_valid stays high; slot freed only after the W handshake.
- With CORE2AXI_PIPE_ERR_EN: b_resp 2'b10 -> data_err_o 1 with the data_rvalid_o pulse. Also: rst_ni low with 2 reads outstanding -> cnt 0 and all valids 0 immediately.
